// File: rtl/ha_sched_pkg.sv
// ha_sched_pkg: shared types and constants for the serial half-adder scheduler.
//   state_t       - scheduler FSM states
//   DEFAULT_WIDTH - default operand width
//   req_id_t      - requester identifier (two requesters, so one bit)
package ha_sched_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/ha_serial_sched_if.sv
// ha_serial_sched_if: request/response bus between two requesters, one
// result consumer and the scheduler.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_a/req_b         : operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum/rsp_cout : result owner, sum and carry out
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. Ready may depend combinationally
// on valid; the payload must be stable while valid is high and not yet
// accepted, and the producer may not assume acceptance before that edge.
interface ha_serial_sched_if
    import ha_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    req_id_t            rsp_id;
    logic [WIDTH-1:0]   rsp_sum;
    logic               rsp_cout;

    // Requester / consumer side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

endinterface

// File: rtl/ha_serial_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   en         : arbitration allowed (scheduler idle)
//   req_valid  : request per requester
//   grant      : one-hot grant, zero when en is low or nothing is requested
//   accept     : a grant was issued this cycle (grant implies valid)
//   grant_id   : index of the granted requester
// The arbiter remembers the last accepted requester; on a tie the other one
// wins. last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2
    import ha_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant,
    output logic       accept,
    output req_id_t    grant_id
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept   = |grant;
    assign grant_id = grant[1];

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ha_serial_sched.sv
// ha_serial_sched: shares one external combinational half adder between two
// requesters. Each accepted request is a WIDTH-bit add performed LSB first,
// two half-adder passes per bit:
//   PASS1: (A[i], B[i])     -> s1 = partial sum, c1 = partial carry
//   PASS2: (s1, carry_in)   -> sum[i], carry_out = c1 | carry
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : request/response handshake bus
//   busy               : scheduler not idle
//   ha_a, ha_b         : operands driven to the shared half adder
//   ha_sum, ha_carry   : half adder results (a^b, a&b), combinational
//   dbg_state          : current FSM state
// Latency: handshake in cycle T gives rsp_valid in cycle T+2*WIDTH+1.
module ha_serial_sched
    import ha_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    ha_serial_sched_if.slave    bus,
    output logic                busy,
    output logic                ha_a,
    output logic                ha_b,
    input  logic                ha_sum,
    input  logic                ha_carry,
    output state_t              dbg_state
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic             carry_q, carry_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    req_id_t          id_q, id_d;

    logic [1:0]       grant;
    logic             accept;
    req_id_t          grant_id;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == S_IDLE),
        .req_valid (bus.req_valid),
        .grant     (grant),
        .accept    (accept),
        .grant_id  (grant_id)
    );

    // State register (FSM state plus serial datapath).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            s1_q      <= 1'b0;
            c1_q      <= 1'b0;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            bit_idx_q <= bit_idx_d;
            carry_q   <= carry_d;
            s1_q      <= s1_d;
            c1_q      <= c1_d;
            id_q      <= id_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        bit_idx_d = bit_idx_q;
        carry_d   = carry_q;
        s1_d      = s1_q;
        c1_d      = c1_q;
        id_d      = id_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d       = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                    b_d       = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                    id_d      = grant_id;
                    bit_idx_d = '0;
                    carry_d   = 1'b0;
                    state_d   = S_PASS1;
                end
            end
            S_PASS1: begin
                s1_d    = ha_sum;
                c1_d    = ha_carry;
                state_d = S_PASS2;
            end
            S_PASS2: begin
                sum_d[bit_idx_q] = ha_sum;
                // At most one of the two partial carries can be set.
                carry_d = c1_q | ha_carry;
                if (bit_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    state_d   = S_PASS1;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        case (state_q)
            S_PASS1: begin
                ha_a = a_q[bit_idx_q];
                ha_b = b_q[bit_idx_q];
            end
            S_PASS2: begin
                ha_a = s1_q;
                ha_b = carry_q;
            end
            default: begin
                ha_a = 1'b0;
                ha_b = 1'b0;
            end
        endcase
    end

    // grant is already gated to IDLE inside the arbiter.
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = carry_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ha_serial_sched.sv
// Directed bench for ha_serial_sched: a WIDTH=8 instance for the functional,
// arbitration, back-pressure, reset and pass-level steps, and a WIDTH=4
// instance for the exhaustive add sweep. Both share the half-adder model.
module tb_ha_serial_sched;
    import ha_sched_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    ha_serial_sched_if #(.WIDTH(8)) bus8 ();
    ha_serial_sched_if #(.WIDTH(4)) bus4 ();

    logic   busy8, ha_a8, ha_b8, ha_sum8, ha_carry8;
    logic   busy4, ha_a4, ha_b4, ha_sum4, ha_carry4;
    state_t state8, state4;

    assign ha_sum8   = ha_a8 ^ ha_b8;
    assign ha_carry8 = ha_a8 & ha_b8;
    assign ha_sum4   = ha_a4 ^ ha_b4;
    assign ha_carry4 = ha_a4 & ha_b4;

    ha_serial_sched #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .busy(busy8),
        .ha_a(ha_a8), .ha_b(ha_b8), .ha_sum(ha_sum8), .ha_carry(ha_carry8),
        .dbg_state(state8)
    );

    ha_serial_sched #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .busy(busy4),
        .ha_a(ha_a4), .ha_b(ha_b4), .ha_sum(ha_sum4), .ha_carry(ha_carry4),
        .dbg_state(state4)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the WIDTH=8 instance shows rsp_valid; lat is the cycle
    // distance from the handshake cycle c0.
    task automatic wait_rsp8(input int c0, output int lat, output logic busy_all);
        int n;
        n = 0;
        busy_all = 1'b1;
        while (bus8.rsp_valid !== 1'b1 && n < 100) begin
            busy_all = busy_all & busy8;
            step();
            n++;
        end
        if (bus8.rsp_valid !== 1'b1) check("rsp8_timeout", 32'(bus8.rsp_valid), 32'd1);
        busy_all = busy_all & busy8;
        lat = cyc - c0;
    endtask

    task automatic wait_rsp4(input int c0, output int lat);
        int n;
        n = 0;
        while (bus4.rsp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (bus4.rsp_valid !== 1'b1) check("rsp4_timeout", 32'(bus4.rsp_valid), 32'd1);
        lat = cyc - c0;
    endtask

    task automatic check_rsp8(input string tag, input logic id, input logic [7:0] sum,
                              input logic cout, input int lat);
        check({tag, "_id"},   32'(bus8.rsp_id),   32'(id));
        check({tag, "_sum"},  32'(bus8.rsp_sum),  32'(sum));
        check({tag, "_cout"}, 32'(bus8.rsp_cout), 32'(cout));
        check({tag, "_lat"},  32'(lat),           32'd17);
    endtask

    // Watchdog: the directed sequence is a few thousand cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          c0;
        int          lat;
        logic        busy_all;
        logic        seen;
        logic        idv;
        logic [3:0]  av, bv;
        logic [3:0]  other_a, other_b;
        logic [4:0]  exp5;

        rst = 1'b1;
        bus8.req_valid = 2'b00; bus8.req_a = '0; bus8.req_b = '0; bus8.rsp_ready = 1'b0;
        bus4.req_valid = 2'b00; bus4.req_a = '0; bus4.req_b = '0; bus4.rsp_ready = 1'b1;

        // ---- reset state ----
        step();
        step();
        check("rst_state",     32'(state8),          32'(S_IDLE));
        check("rst_req_ready", 32'(bus8.req_ready),  32'd0);
        check("rst_rsp_valid", 32'(bus8.rsp_valid),  32'd0);
        check("rst_busy",      32'(busy8),           32'd0);
        check("rst_ha_a",      32'(ha_a8),           32'd0);
        check("rst_ha_b",      32'(ha_b8),           32'd0);
        check("rst_rsp_sum",   32'(bus8.rsp_sum),    32'd0);
        check("rst_rsp_cout",  32'(bus8.rsp_cout),   32'd0);
        check("rst_rsp_id",    32'(bus8.rsp_id),     32'd0);
        check("rst4_rsp_valid", 32'(bus4.rsp_valid), 32'd0);
        rst = 1'b0;
        step();

        // ---- basic add: FF + 01 on requester 0 ----
        bus8.req_a = {8'h00, 8'hFF};
        bus8.req_b = {8'h00, 8'h01};
        bus8.req_valid = 2'b01;
        bus8.rsp_ready = 1'b1;
        #1;
        check("basic_grant", 32'(bus8.req_ready), 32'b01);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b00;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("basic", 1'b0, 8'h00, 1'b1, lat);
        check("basic_busy", 32'(busy_all), 32'd1);
        step();
        check("basic_consumed_state", 32'(state8), 32'(S_IDLE));
        check("basic_consumed_valid", 32'(bus8.rsp_valid), 32'd0);

        // ---- contention from a fresh reset ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus8.req_a = {8'hA5, 8'h12};
        bus8.req_b = {8'h5B, 8'h34};
        bus8.req_valid = 2'b11;
        #1;
        check("cont_grant0", 32'(bus8.req_ready), 32'b01);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b10;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("cont_r0", 1'b0, 8'h46, 1'b0, lat);
        check("cont_done_ready", 32'(bus8.req_ready), 32'b00);
        step();
        check("cont_idle_state", 32'(state8), 32'(S_IDLE));
        check("cont_grant1", 32'(bus8.req_ready), 32'b10);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b00;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("cont_r1", 1'b1, 8'h00, 1'b1, lat);
        step();

        // second simultaneous pair: last_grant is 1, so requester 0 wins
        bus8.req_a = {8'h80, 8'h0F};
        bus8.req_b = {8'h7F, 8'hF1};
        bus8.req_valid = 2'b11;
        #1;
        check("pair2_grant0", 32'(bus8.req_ready), 32'b01);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b10;
        bus8.rsp_ready = 1'b0;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("pair2_r0", 1'b0, 8'h00, 1'b1, lat);

        // ---- back-pressure: hold DONE for 10 cycles, requester 1 pending ----
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(bus8.rsp_valid), 32'd1);
            check("bp_sum",   32'(bus8.rsp_sum),   32'h00);
            check("bp_cout",  32'(bus8.rsp_cout),  32'd1);
            check("bp_ready", 32'(bus8.req_ready), 32'b00);
        end
        bus8.rsp_ready = 1'b1;
        step();
        check("bp_consumed_state", 32'(state8), 32'(S_IDLE));
        check("bp_consumed_valid", 32'(bus8.rsp_valid), 32'd0);
        check("bp_next_grant", 32'(bus8.req_ready), 32'b10);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b00;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("pair2_r1", 1'b1, 8'hFF, 1'b0, lat);
        step();

        // ---- reset in PASS2 of bit 3 (requester 1: 0F + 01) ----
        bus8.req_a = {8'h0F, 8'h00};
        bus8.req_b = {8'h01, 8'h00};
        bus8.req_valid = 2'b10;
        #1;
        step();
        bus8.req_valid = 2'b00;
        repeat (7) step();
        check("abort_in_pass2", 32'(state8), 32'(S_PASS2));
        check("abort_ha_a_b3", 32'(ha_a8), 32'd1);
        check("abort_ha_b_b3", 32'(ha_b8), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state",     32'(state8),         32'(S_IDLE));
        check("abort_busy",      32'(busy8),          32'd0);
        check("abort_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
        check("abort_rsp_sum",   32'(bus8.rsp_sum),   32'd0);
        check("abort_rsp_cout",  32'(bus8.rsp_cout),  32'd0);
        check("abort_rsp_id",    32'(bus8.rsp_id),    32'd0);
        check("abort_ha_a",      32'(ha_a8),          32'd0);
        check("abort_ha_b",      32'(ha_b8),          32'd0);
        check("abort_req_ready", 32'(bus8.req_ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | bus8.rsp_valid;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);

        bus8.req_a = {8'h00, 8'h3C};
        bus8.req_b = {8'h00, 8'hC5};
        bus8.req_valid = 2'b01;
        #1;
        check("after_abort_grant", 32'(bus8.req_ready), 32'b01);
        c0 = cyc;
        step();
        bus8.req_valid = 2'b00;
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("after_abort", 1'b0, 8'h01, 1'b1, lat);
        step();

        // ---- pass-level: 01 + 01 ----
        bus8.req_a = {8'h00, 8'h01};
        bus8.req_b = {8'h00, 8'h01};
        bus8.req_valid = 2'b01;
        #1;
        c0 = cyc;
        step();
        bus8.req_valid = 2'b00;
        check("pl_b0p1_state", 32'(state8), 32'(S_PASS1));
        check("pl_b0p1_a", 32'(ha_a8), 32'd1);
        check("pl_b0p1_b", 32'(ha_b8), 32'd1);
        step();
        check("pl_b0p2_a", 32'(ha_a8), 32'd0);
        check("pl_b0p2_b", 32'(ha_b8), 32'd0);
        step();
        check("pl_b1p1_a", 32'(ha_a8), 32'd0);
        check("pl_b1p1_b", 32'(ha_b8), 32'd0);
        step();
        check("pl_b1p2_state", 32'(state8), 32'(S_PASS2));
        check("pl_b1p2_a", 32'(ha_a8), 32'd0);
        check("pl_b1p2_b", 32'(ha_b8), 32'd1);
        wait_rsp8(c0, lat, busy_all);
        check_rsp8("pl", 1'b0, 8'h02, 1'b0, lat);
        step();

        // ---- exhaustive WIDTH=4, alternating requesters ----
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                av  = 4'(a);
                bv  = 4'(b);
                idv = 1'((a * 16 + b) % 2);
                other_a = 4'($urandom_range(0, 15));
                other_b = 4'($urandom_range(0, 15));
                bus4.req_a = idv ? {av, other_a} : {other_a, av};
                bus4.req_b = idv ? {bv, other_b} : {other_b, bv};
                bus4.req_valid = idv ? 2'b10 : 2'b01;
                #1;
                check("ex_grant", 32'(bus4.req_ready), idv ? 32'b10 : 32'b01);
                c0 = cyc;
                step();
                bus4.req_valid = 2'b00;
                wait_rsp4(c0, lat);
                exp5 = 5'(a + b);
                check("ex_sum", 32'({bus4.rsp_cout, bus4.rsp_sum}), 32'(exp5));
                check("ex_id",  32'(bus4.rsp_id), 32'(idv));
                check("ex_lat", 32'(lat), 32'd9);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
